reg_share_arb: RTL and testbench
================================

REG_SHARE_ARB -- requirements
Module: reg_share_arb

Interface
REQ-001 Parameter N, 4, number of requesters sharing the register (2..8).
REQ-002 Parameter W, 8, data width of the shared register.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rstn  input  1  asynchronous active-low reset; the only reset.
REQ-005 req  input  N  per-requester request; held high until its ack.
REQ-006 d  input  N*W  per-requester write data; slice i = d[i*W +: W].
REQ-007 gnt  output  N  one-hot grant; high only in LOAD.
REQ-008 ack  output  N  one-hot completion pulse; high only in ACK.
REQ-009 q  output  W  shared register contents.
REQ-010 owner  output  clog2(N)  index of the current or last granted requester.
REQ-011 busy  output  1  high whenever state is not IDLE.

Function
REQ-012 Use a three-state FSM: IDLE, LOAD, ACK.
REQ-013 In IDLE with any req high: on the next edge, latch the winner into owner and go to LOAD; with no req high, stay in IDLE.
REQ-014 Select the winner round-robin: the first req bit set, searching from ptr upward and wrapping from N-1 to 0.
REQ-015 In LOAD, drive gnt[owner]=1; if req[owner] is still high, on the next edge q <= d[owner] and go to ACK.
REQ-016 In LOAD with req[owner] low: abort to IDLE; q is unchanged, no ack is issued, and ptr is unchanged.
REQ-017 In ACK, drive ack[owner]=1 for exactly one cycle; on the next edge go to IDLE and set ptr <= (owner+1) mod N.
REQ-018 Latency: req is sampled at edge k, q is updated at edge k+1, and ack is high for the cycle between edges k+1 and k+2.
REQ-019 The minimum spacing between consecutive grants is 3 cycles; no requester waits more than N grants.
REQ-020 q holds its value in every state except the LOAD->ACK transition.
REQ-021 Requests arriving while busy are ignored until IDLE; they are not lost as long as req stays high.

Reset
REQ-022 While rstn=0, asynchronously force: state=IDLE, q=0, gnt=0, ack=0, owner=0, ptr=0, busy=0.
REQ-023 Reset asserted mid-transaction discards it: no ack is issued, and q returns to 0.
REQ-024 After rstn deasserts, the first arbitration starts at the first clk edge with req nonzero.

Configuration
REQ-025 Macro REG_SHARE_LOCK_EN, when defined, adds input lock (N bits).
REQ-026 With REG_SHARE_LOCK_EN, in ACK with lock[owner]=1: go to LOAD with the same owner and do not advance ptr.
  - This gives back-to-back loads every 2 cycles.
  - Lock is ignored in IDLE.
REQ-027 Without the macro: the lock port is absent, and ACK always returns to IDLE.

Structure
REQ-028 Package reg_share_pkg holds:
  - the FSM state enum (IDLE, LOAD, ACK);
  - the default N and W constants.
REQ-029 The round-robin priority selection is a combinational sub-module rr_pick(req, ptr -> hit, idx).

Verification
REQ-030 Reset check: rstn=0 at t=0, released at 18 ns with req=0 -> q=0, busy=0, gnt=0, ack=0 throughout.
REQ-031 Single request: req=4'b0100, d[2]=8'hA5 -> gnt[2] high 1 cycle, then q=8'hA5 and ack[2] high 1 cycle, then IDLE.
REQ-032 Fairness: req=4'b1111 held, distinct data per requester -> ack order 0,1,2,3,0; each transaction 3 cycles.
REQ-033 Abort: req[1] dropped during LOAD -> no ack[1], q unchanged, next winner searched from 1 again.
REQ-034 Mid-operation reset: rstn low during ACK of requester 3 -> ack drops immediately, q=0, ptr=0.
REQ-035 Lock (REG_SHARE_LOCK_EN defined): req=4'b0011, lock[0] high for 2 acks -> owner 0 twice (every 2 cycles), then owner 1.

Source files
------------

// File: rtl/reg_share_pkg.sv
// Shared definitions for the round-robin shared-register arbiter.
package reg_share_pkg;

  localparam int N_DEF = 4;
  localparam int W_DEF = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    ACK  = 2'd2
  } state_e;

endpackage

// File: rtl/reg_share_arb_rr_pick.sv
// Round-robin pick: the first set request bit at or above ptr, wrapping at N-1.
module rr_pick #(
  parameter int N  = 4,
  parameter int IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] ptr,
  output logic          hit,
  output logic [IW-1:0] idx
);

  logic [IW:0] pos;

  // Scan from the farthest offset down, so the nearest set bit after ptr wins.
  always_comb begin
    hit = 1'b0;
    idx = '0;
    pos = '0;
    for (int k = N - 1; k >= 0; k--) begin
      pos = {1'b0, ptr} + (IW+1)'(k);
      if (pos >= (IW+1)'(N)) pos = pos - (IW+1)'(N);
      if (req[pos[IW-1:0]]) begin
        hit = 1'b1;
        idx = pos[IW-1:0];
      end
    end
  end

endmodule

// File: rtl/reg_share_arb.sv
// Shared register arbiter: N requesters take turns writing one W-bit register
// through an IDLE -> LOAD -> ACK handshake, winners chosen round-robin.
// Optional macro REG_SHARE_LOCK_EN adds a per-requester lock input that keeps
// the current owner for another load straight from ACK.
module reg_share_arb
  import reg_share_pkg::*;
#(
  parameter int N = N_DEF,
  parameter int W = W_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic [N-1:0]         req,
  input  logic [N*W-1:0]       d,
`ifdef REG_SHARE_LOCK_EN
  input  logic [N-1:0]         lock,
`endif
  output logic [N-1:0]         gnt,
  output logic [N-1:0]         ack,
  output logic [W-1:0]         q,
  output logic [$clog2(N)-1:0] owner,
  output logic                 busy
);

  localparam int IW = $clog2(N);

  state_e        state_q, state_d;
  logic [IW-1:0] owner_q, owner_d;
  logic [IW-1:0] ptr_q, ptr_d;
  logic [W-1:0]  data_q, data_d;
  logic          pick_hit;
  logic [IW-1:0] pick_idx;
  logic [IW-1:0] nxt_ptr;

  rr_pick #(.N(N), .IW(IW)) u_pick (
    .req (req),
    .ptr (ptr_q),
    .hit (pick_hit),
    .idx (pick_idx)
  );

  // Priority moves just past the requester that completed.
  assign nxt_ptr = (owner_q == IW'(N - 1)) ? '0 : owner_q + 1'b1;

  // Next-state, grant and ack decode; ptr only advances on a finished write.
  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    gnt     = '0;
    ack     = '0;
    case (state_q)
      IDLE: begin
        if (pick_hit) begin
          owner_d = pick_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        gnt[owner_q] = 1'b1;
        if (req[owner_q]) begin
          data_d  = d[owner_q*W +: W];
          state_d = ACK;
        end else begin
          state_d = IDLE;
        end
      end
      ACK: begin
        ack[owner_q] = 1'b1;
`ifdef REG_SHARE_LOCK_EN
        if (lock[owner_q]) begin
          state_d = LOAD;
        end else begin
          state_d = IDLE;
          ptr_d   = nxt_ptr;
        end
`else
        state_d = IDLE;
        ptr_d   = nxt_ptr;
`endif
      end
      default: state_d = IDLE;
    endcase
  end

  // State registers; reset drops any transaction in flight.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q <= IDLE;
      owner_q <= '0;
      ptr_q   <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
    end
  end

  assign q     = data_q;
  assign owner = owner_q;
  assign busy  = (state_q != IDLE);

endmodule

// File: tb/tb_reg_share_arb.sv
// Bench for reg_share_arb (N=4, W=8); lock scenario runs when REG_SHARE_LOCK_EN is defined.
module tb_reg_share_arb;

  localparam int N = 4;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rstn;
  logic [N-1:0] req;
  logic [N*W-1:0] d;
  logic [N-1:0] lock;
  logic [N-1:0] gnt, ack;
  logic [W-1:0] q;
  logic [1:0]   owner;
  logic         busy;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  reg_share_arb #(.N(N), .W(W)) dut (
    .clk   (clk),
    .rstn  (rstn),
    .req   (req),
    .d     (d),
`ifdef REG_SHARE_LOCK_EN
    .lock  (lock),
`endif
    .gnt   (gnt),
    .ack   (ack),
    .q     (q),
    .owner (owner),
    .busy  (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
  endtask

  // Transaction-level model: an active transfer has an age (0 = load cycle,
  // 1 = ack cycle); the pointer and register change only on completion.
  bit         m_act = 0;
  int         m_age = 0;
  int         m_own = 0;
  int         m_ptr = 0;
  logic [7:0] m_q   = '0;

  initial begin
    forever begin
      @(posedge clk or negedge rstn);
      if (!rstn) begin
        m_act = 0; m_age = 0; m_own = 0; m_ptr = 0; m_q = '0;
      end else if (!m_act) begin
        if (req != 0) begin
          for (int k = N - 1; k >= 0; k--)
            if (req[(m_ptr + k) % N]) m_own = (m_ptr + k) % N;
          m_act = 1; m_age = 0;
        end
      end else if (m_age == 0) begin
        if (req[m_own]) begin
          m_q = d[m_own*W +: W];
          m_age = 1;
        end else begin
          m_act = 0;
        end
      end else begin
`ifdef REG_SHARE_LOCK_EN
        if (lock[m_own]) m_age = 0;
        else begin m_act = 0; m_ptr = (m_own + 1) % N; end
`else
        m_act = 0; m_ptr = (m_own + 1) % N;
`endif
      end
    end
  end

  // Per-cycle compare against the model, sampled mid-cycle.
  initial begin
    logic [N-1:0] eg, ea;
    forever begin
      @(negedge clk);
      eg = '0; ea = '0;
      if (m_act && m_age == 0) eg[m_own] = 1'b1;
      if (m_act && m_age == 1) ea[m_own] = 1'b1;
      chk("cyc_gnt",   32'(gnt),   32'(eg));
      chk("cyc_ack",   32'(ack),   32'(ea));
      chk("cyc_q",     32'(q),     32'(m_q));
      chk("cyc_owner", 32'(owner), 32'(m_own));
      chk("cyc_busy",  32'(busy),  32'(m_act));
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic wait_ack(output int idx, output int at);
    idx = -1; at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (ack != 0) begin
        for (int j = 0; j < N; j++) if (ack[j]) idx = j;
        at = cyc;
        break;
      end
    end
  endtask

  task automatic do_reset();
    #2 rstn = 1'b0;
    #5 rstn = 1'b1;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int idx, t0, t1;
    int exp_ord[5] = '{0, 1, 2, 3, 0};
    logic [7:0] exp_q[5] = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h11};
    int at[5];

    rstn = 1'b0; req = '0; d = '0; lock = '0;
    #17;
    chk("rst_q", 32'(q), 0);
    chk("rst_busy", 32'(busy), 0);
    #1 rstn = 1'b1;
    tick(); tick();
    chk("post_rst_busy", 32'(busy), 0);
    chk("post_rst_gnt", 32'(gnt), 0);

    // single request
    d[23:16] = 8'hA5; req = 4'b0100;
    wait_ack(idx, t0);
    chk("single_idx", idx, 2);
    chk("single_q", 32'(q), 32'hA5);
    tick(); req[2] = 1'b0;
    tick(); tick();
    chk("single_idle", 32'(busy), 0);

    // fairness from a fresh pointer
    do_reset();
    chk("rst2_q", 32'(q), 0);
    d = {8'h44, 8'h33, 8'h22, 8'h11};
    req = 4'b1111;
    for (int n = 0; n < 5; n++) begin
      wait_ack(idx, at[n]);
      chk("fair_idx", idx, exp_ord[n]);
      chk("fair_q", 32'(q), 32'(exp_q[n]));
      if (n > 0) chk("fair_spacing", at[n] - at[n-1], 3);
    end
    tick(); req = '0;
    tick(); tick();

    // abort during LOAD (pointer now at 1)
    d[15:8] = 8'h5A; req = 4'b0010;
    tick();
    chk("abort_gnt", 32'(gnt), 32'b0010);
    req = '0;
    tick();
    chk("abort_busy", 32'(busy), 0);
    tick(); tick(); tick();
    chk("abort_q", 32'(q), 32'h11);
    d[7:0] = 8'h66; req = 4'b0011;
    wait_ack(idx, t0);
    chk("abort_next_idx", idx, 1);
    chk("abort_next_q", 32'(q), 32'h5A);
    tick(); req[1] = 1'b0;
    wait_ack(idx, t0);
    chk("abort_then0_idx", idx, 0);
    chk("abort_then0_q", 32'(q), 32'h66);
    tick(); req = '0;
    tick();

    // reset during ACK of requester 3
    d[31:24] = 8'hC3; req = 4'b1000;
    wait_ack(idx, t0);
    chk("mid_idx", idx, 3);
    chk("mid_q_before", 32'(q), 32'hC3);
    #2 rstn = 1'b0;
    #1;
    chk("mid_ack", 32'(ack), 0);
    chk("mid_q", 32'(q), 0);
    chk("mid_busy", 32'(busy), 0);
    chk("mid_owner", 32'(owner), 0);
    #3 rstn = 1'b1;
    req = 4'b1111;
    wait_ack(idx, t0);
    chk("mid_ptr0_idx", idx, 0);
    tick(); req = '0;
    tick(); tick();

`ifdef REG_SHARE_LOCK_EN
    do_reset();
    req = 4'b0011; lock = 4'b0001;
    wait_ack(idx, t0);
    chk("lock_first", idx, 0);
    tick(); lock = '0;
    wait_ack(idx, t1);
    chk("lock_second", idx, 0);
    chk("lock_spacing", t1 - t0, 2);
    tick(); req[0] = 1'b0;
    wait_ack(idx, t0);
    chk("lock_then1", idx, 1);
    tick(); req = '0;
    tick();
`endif

    tick(); tick();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
